pipe_tracker: RTL and testbench
===============================

# pipe_tracker

Parametrised pipeline-tracking unit for the MIPS pipelined core. It replaces the hand-coded PC_IF_ID / PC_ID_EX / PC_EX_MEM / PC_MEM_WB chain with a generic STAGES-deep register chain of PC and valid bits. Each stage supports stall (hold plus bubble insertion), flush (squash), and precise exception capture. Fetch, the hazard unit and the controller drive per-stage requests; the tracker reports per-stage PC/valid, the exception PC and cause, and retirement.

## Interface
Parameters:
- XLEN, 32, PC width in bits
- STAGES, 5, number of tracked stages (index 0 = IF/ID, STAGES-1 = last stage before retire); legal range 2..8
- CAUSE_W, 4, exception cause code width

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  reset; one clock, synchronous, active-low
- fetch_valid  in  1  a fetched instruction is offered this cycle
- fetch_pc  in  XLEN  PC of the offered instruction
- fetch_ready  out  1  stage 0 accepts this cycle; = ~|stall_req (combinational)
- stall_req  in  STAGES  bit i: stage i must hold
- flush_req  in  STAGES  bit i: squash stages 0..i
- exc_req  in  STAGES  bit i: stage i raises an exception
- exc_cause  in  STAGES*CAUSE_W  cause for stage i in bits [i*CAUSE_W +: CAUSE_W]
- exc_ack  in  1  handler has consumed the pending exception
- stage_pc  out  STAGES*XLEN  registered PC per stage
- stage_valid  out  STAGES  registered valid per stage
- exception  out  1  sticky: exception pending
- epc  out  XLEN  PC of the captured excepting instruction
- cause  out  CAUSE_W  captured cause
- retire_valid  out  1  last stage retires this cycle (combinational)
- retire_pc  out  XLEN  = stage_pc of stage STAGES-1
- retired_count  out  32  retired-instruction counter
- stall_count  out  32  cycles with any stall_req set

## Operation
- Request qualification: stall_req, flush_req and exc_req bits count only when the matching stage_valid is 1. Exception: flush_req bits act unconditionally.
- Stall index s = highest qualified stall bit.
  - Stages 0..s hold their contents.
  - Stage s+1 loads a bubble (valid=0, PC unchanged).
  - Stages above s+1 advance.
  - fetch_ready = 0.
- Exception index e = highest qualified exc_req bit (the oldest instruction wins).
  - If exception = 0, or exc_ack = 1 in the same cycle: capture epc = stage_pc[e] and cause = exc_cause[e], and set exception = 1.
  - If exception = 1 and exc_ack = 0: the new request is ignored and its stage is still squashed.
- Effective flush index f = max(highest flush_req bit, e). Stages 0..f load valid = 0. Flush overrides stall for those stages.
- With no stall and no flush, each stage k>0 loads stage k-1, and stage 0 loads {fetch_valid, fetch_pc}.
  - If flush covers stage 0 in the same cycle, the fetched instruction is discarded.
- retire_valid = stage_valid[STAGES-1] & ~stall_req[STAGES-1] & ~(qualified exc_req[STAGES-1]) & ~(flush index = STAGES-1).
- exc_ack with exception = 1 and no new capture: exception clears at the next edge. epc and cause keep their values until the next capture.
- Arithmetic: both counters are 32-bit unsigned and wrap from 0xFFFFFFFF to 0. No saturation.

## Timing
- Reset: every output register is 0 (stage_pc, stage_valid, exception, epc, cause, retired_count, stall_count). Reset applied mid-operation clears everything at that edge and overrides all requests.
- Fetch accepted at edge N shows in stage 0 after edge N. Uninterrupted, it reaches stage STAGES-1 after edge N+STAGES-1 and retires in that cycle.
- Every stall cycle adds exactly one cycle of latency for instructions at or below s.
- The exception signal is visible the cycle after exc_req. Squashed stages show valid = 0 in that same cycle.
- All state updates happen on the rising clk edge. Only fetch_ready and retire_valid are combinational.

## Configuration
- PIPE_TRACKER_PERF_EN
  - Defined: retired_count increments on each retire_valid cycle; stall_count increments on each cycle with any qualified stall bit.
  - Not defined: both outputs are constant 0 and no counter flops are built.
  - All other behaviour is identical in both builds.

## Test plan
- Streaming, STAGES=5: fetch PCs 0x0, 0x4, 0x8… every cycle -> 0x0 retires in the cycle after edge 5; retired_count=3 after 3 retires.
- Stall: stall_req[1]=1 for 2 cycles while PCs 0x10 (stage 1) and 0x14 (stage 0) are held -> stage 2 valid=0 for 2 cycles; fetch_ready=0; stall_count=2; 0x10 resumes afterwards.
- Flush: flush_req[1] with stages 0..3 valid -> next cycle stage_valid=5'b11000 shifted (stages 0..1 squashed, older advance); fetch_pc discarded.
- Exception: exc_req[2] (PC 0x40, cause 4'hC) and exc_req[3] (PC 0x3C, cause 4'h1) in the same cycle -> epc=0x3C, cause=1, exception=1, stages 0..3 invalid.
- Exception while pending: second exc_req with exc_ack=0 -> epc unchanged, stage squashed. exc_ack together with new exc_req -> new epc captured, exception stays 1.
- Reset mid-run: drop rst_n for one edge with all stages valid -> all outputs 0 at the next cycle; counters 0 (both builds).

Source files
------------

// File: rtl/pipe_tracker.sv
// pipe_tracker: STAGES-deep PC/valid pipeline tracker with stall, flush and precise exception capture
// Ports: fetch_valid/fetch_pc offer an instruction to stage 0, fetch_ready = no stall_req bit set;
//   stall_req/flush_req/exc_req/exc_cause are per-stage requests, exc_ack consumes the pending exception;
//   stage_pc/stage_valid expose every stage, exception/epc/cause hold the captured exception,
//   retire_valid/retire_pc describe the last stage, retired_count/stall_count are perf counters.
// Define PIPE_TRACKER_PERF_EN to build the counters; without it they are tied to 0.
module pipe_tracker #(
  parameter int XLEN = 32,
  parameter int STAGES = 5,
  parameter int CAUSE_W = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       fetch_valid,
  input  logic [XLEN-1:0]            fetch_pc,
  output logic                       fetch_ready,
  input  logic [STAGES-1:0]          stall_req,
  input  logic [STAGES-1:0]          flush_req,
  input  logic [STAGES-1:0]          exc_req,
  input  logic [STAGES*CAUSE_W-1:0]  exc_cause,
  input  logic                       exc_ack,
  output logic [STAGES*XLEN-1:0]     stage_pc,
  output logic [STAGES-1:0]          stage_valid,
  output logic                       exception,
  output logic [XLEN-1:0]            epc,
  output logic [CAUSE_W-1:0]         cause,
  output logic                       retire_valid,
  output logic [XLEN-1:0]            retire_pc,
  output logic [31:0]                retired_count,
  output logic [31:0]                stall_count
);
  localparam int L = STAGES - 1;
  logic [STAGES-1:0][XLEN-1:0] pc, pc_n;
  logic [STAGES-1:0][CAUSE_W-1:0] ec;
  logic [STAGES-1:0] v, v_n, qs, qe, hold, kill, bub;
  logic hf, kf, capture;
  logic [XLEN-1:0] epc_n;
  logic [CAUSE_W-1:0] cause_n;
  assign ec = exc_cause;
  assign qs = stall_req & v;
  assign qe = exc_req & v;
  assign fetch_ready = ~|stall_req;
  assign retire_valid = v[L] & ~stall_req[L] & ~qe[L] & ~flush_req[L];
  assign retire_pc = pc[L];
  assign stage_pc = pc;
  assign stage_valid = v;
  assign capture = |qe & (~exception | exc_ack);
  // hold/kill are "at or below the highest request" masks; a stall bubble
  // enters the first stage above the held region. A stage whose source was
  // killed this cycle advances a bubble so squashed work never moves up.
  always_comb begin
    hf = 1'b0;
    kf = 1'b0;
    hold = '0;
    kill = '0;
    for (int k = STAGES - 1; k >= 0; k--) begin
      hf = hf | qs[k];
      kf = kf | flush_req[k] | qe[k];
      hold[k] = hf;
      kill[k] = kf;
    end
    bub = ~hold & {hold[STAGES-2:0], 1'b0};
    pc_n[0] = hold[0] ? pc[0] : fetch_pc;
    // an offer is taken only when fetch_ready, so a refused offer is not lost
    v_n[0] = ~kill[0] & (hold[0] ? v[0] : fetch_valid & fetch_ready);
    for (int k = 1; k < STAGES; k++) begin
      pc_n[k] = (hold[k] | bub[k]) ? pc[k] : pc[k-1];
      v_n[k] = ~kill[k] & (hold[k] ? v[k] : ~bub[k] & v[k-1] & ~kill[k-1]);
    end
    epc_n = pc[0];
    cause_n = ec[0];
    for (int k = 0; k < STAGES; k++) begin
      epc_n = qe[k] ? pc[k] : epc_n;
      cause_n = qe[k] ? ec[k] : cause_n;
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc <= '0;
      v <= '0;
      exception <= 1'b0;
      epc <= '0;
      cause <= '0;
    end else begin
      pc <= pc_n;
      v <= v_n;
      if (capture) begin
        exception <= 1'b1;
        epc <= epc_n;
        cause <= cause_n;
      end else if (exc_ack) begin
        exception <= 1'b0;
      end
    end
  end
`ifdef PIPE_TRACKER_PERF_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      retired_count <= '0;
      stall_count <= '0;
    end else begin
      retired_count <= retired_count + {31'd0, retire_valid};
      stall_count <= stall_count + {31'd0, |qs};
    end
  end
`else
  assign retired_count = '0;
  assign stall_count = '0;
`endif
endmodule

// File: tb/tb_pipe_tracker.sv
// tb_pipe_tracker: directed scoreboard bench for pipe_tracker (STAGES=5)
module tb_pipe_tracker;
  localparam int S = 5;
`ifdef PIPE_TRACKER_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst_n;
  logic fetch_valid;
  logic [31:0] fetch_pc;
  logic fetch_ready;
  logic [S-1:0] stall_req, flush_req, exc_req;
  logic [S*4-1:0] exc_cause;
  logic exc_ack;
  logic [S*32-1:0] stage_pc;
  logic [S-1:0] stage_valid;
  logic exception;
  logic [31:0] epc;
  logic [3:0] cause;
  logic retire_valid;
  logic [31:0] retire_pc, retired_count, stall_count;
  int checks = 0;
  int errors = 0;
  int n_retired = 0;
  logic [31:0] sb[$];
  pipe_tracker #(.XLEN(32), .STAGES(S), .CAUSE_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .fetch_valid(fetch_valid), .fetch_pc(fetch_pc),
    .fetch_ready(fetch_ready), .stall_req(stall_req), .flush_req(flush_req),
    .exc_req(exc_req), .exc_cause(exc_cause), .exc_ack(exc_ack),
    .stage_pc(stage_pc), .stage_valid(stage_valid), .exception(exception),
    .epc(epc), .cause(cause), .retire_valid(retire_valid), .retire_pc(retire_pc),
    .retired_count(retired_count), .stall_count(stall_count)
  );
  always #5 clk = ~clk;
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask
  function automatic logic [31:0] spc(input int k);
    return stage_pc[k*32 +: 32];
  endfunction
  task automatic cyc();
    @(negedge clk);
    if (retire_valid) begin
      if (sb.size() == 0) chk("retire_unexpected", retire_valid, 0);
      else begin
        chk("retire_pc", retire_pc, sb.pop_front());
        n_retired++;
      end
    end
    @(posedge clk);
    #1;
  endtask
  task automatic fetch(input logic [31:0] p);
    fetch_valid = 1'b1;
    fetch_pc = p;
    sb.push_back(p);
    cyc();
  endtask
  initial begin
    rst_n = 1'b0;
    fetch_valid = 1'b0;
    fetch_pc = '0;
    stall_req = '0;
    flush_req = '0;
    exc_req = '0;
    exc_cause = '0;
    exc_ack = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    chk("rst_valid", stage_valid, 0);
    chk("rst_pc", stage_pc, 0);
    chk("rst_exc", {exception, epc, cause}, 0);
    chk("rst_counts", {retired_count, stall_count}, 0);
    chk("rst_ready", fetch_ready, 1);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) fetch(32'(i * 4));
    #1;
    chk("first_retire_valid", retire_valid, 1);
    chk("first_retire_pc", retire_pc, 32'h0);
    fetch(32'h14);
    stall_req = 5'b00010;
    fetch_valid = 1'b1;
    fetch_pc = 32'h18;
    #1;
    chk("stall_ready_a", fetch_ready, 0);
    cyc();
    chk("stall_valid_a", stage_valid, 5'b11011);
    chk("stall_hold_s1", spc(1), 32'h10);
    #1;
    chk("stall_ready_b", fetch_ready, 0);
    cyc();
    chk("stall_valid_b", stage_valid, 5'b10011);
    chk("stall_count", stall_count, PERF ? 2 : 0);
    chk("retired_count_3", retired_count, PERF ? 3 : 0);
    stall_req = '0;
    fetch(32'h18);
    chk("resume_pc_s2", spc(2), 32'h10);
    chk("resume_valid", stage_valid, 5'b00111);
    fetch(32'h1c);
    chk("pre_flush_valid", stage_valid, 5'b01111);
    flush_req = 5'b00010;
    fetch_valid = 1'b1;
    fetch_pc = 32'h20;
    void'(sb.pop_back());
    void'(sb.pop_back());
    #1;
    chk("flush_no_retire", retire_valid, 0);
    cyc();
    chk("flush_valid", stage_valid, 5'b11000);
    chk("flush_pc_s4", spc(4), 32'h10);
    chk("flush_pc_s3", spc(3), 32'h14);
    flush_req = '0;
    fetch_valid = 1'b0;
    repeat (2) cyc();
    chk("sb_drained", sb.size(), 0);
    chk("drained_valid", stage_valid, 0);
    fetch(32'h3c);
    fetch(32'h40);
    fetch(32'h44);
    fetch(32'h48);
    chk("pre_exc_valid", stage_valid, 5'b01111);
    fetch_valid = 1'b0;
    exc_req = 5'b01100;
    exc_cause = 20'h01c00;
    #1;
    chk("exc_no_retire", retire_valid, 0);
    sb.delete();
    cyc();
    chk("exc_flag", exception, 1);
    chk("exc_epc", epc, 32'h3c);
    chk("exc_cause", cause, 4'h1);
    chk("exc_squash", stage_valid, 0);
    exc_req = '0;
    exc_cause = '0;
    fetch(32'h50);
    chk("exc_sticky", exception, 1);
    fetch_valid = 1'b0;
    exc_req = 5'b00001;
    exc_cause = 20'h00005;
    void'(sb.pop_back());
    cyc();
    chk("pend_epc", epc, 32'h3c);
    chk("pend_cause", cause, 4'h1);
    chk("pend_squash", stage_valid, 0);
    exc_req = '0;
    exc_cause = '0;
    fetch(32'h60);
    fetch_valid = 1'b0;
    exc_req = 5'b00001;
    exc_cause = 20'h00007;
    exc_ack = 1'b1;
    void'(sb.pop_back());
    cyc();
    chk("ack_new_epc", epc, 32'h60);
    chk("ack_new_cause", cause, 4'h7);
    chk("ack_new_flag", exception, 1);
    exc_req = '0;
    exc_cause = '0;
    cyc();
    chk("ack_clear", exception, 0);
    chk("ack_keep_epc", {epc, cause}, {32'h60, 4'h7});
    exc_ack = 1'b0;
    for (int i = 0; i < 5; i++) fetch(32'h80 + 32'(i * 4));
    fetch_valid = 1'b0;
    chk("full_valid", stage_valid, 5'b11111);
    chk("full_pc_s4", spc(4), 32'h80);
    chk("retired_total", retired_count, PERF ? n_retired : 0);
    chk("stall_total", stall_count, PERF ? 2 : 0);
    rst_n = 1'b0;
    fetch_valid = 1'b1;
    fetch_pc = 32'h94;
    stall_req = '1;
    flush_req = '1;
    exc_req = '1;
    exc_cause = '1;
    cyc();
    sb.delete();
    chk("mid_rst_valid", stage_valid, 0);
    chk("mid_rst_pc", stage_pc, 0);
    chk("mid_rst_exc", {exception, epc, cause}, 0);
    chk("mid_rst_counts", {retired_count, stall_count}, 0);
    rst_n = 1'b1;
    fetch_valid = 1'b0;
    stall_req = '0;
    flush_req = '0;
    exc_req = '0;
    exc_cause = '0;
    cyc();
    chk("post_rst_idle", {exception, stage_valid}, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
